// File: rtl/freq_gate_controller_if.sv
// ---------------------------------------------------------------------------
// freq_gate_controller_if
//
// Groups every non-clock, non-reset signal of freq_gate_controller into one
// bundle. The signals are the measured input, the start/abort controls, the
// link to the external BCD counter chain and the latched result.
//
// Parameter:
//   DIGITS_NUM  BCD digit count of the attached counter chain. It must match
//               the controller's own DIGITS_NUM.
//
// Modports:
//   slave   the controller's side. Measurement and counter-chain inputs come
//           in; counter control and the result go out.
//   master  the environment's side, which is the mirror image of slave.
// ---------------------------------------------------------------------------
interface freq_gate_controller_if #(
    parameter int DIGITS_NUM = 6
);
    logic                      signal_in;
    logic                      start_in;
    logic                      abort_in;
    logic [4*DIGITS_NUM-1:0]   counter_digits_in;
    logic                      counter_carry_in;
    logic                      counter_reset_out;
    logic                      counter_enable_out;
    logic [4*DIGITS_NUM-1:0]   result_out;
    logic                      result_valid_out;
    logic                      overflow_out;
    logic                      busy_out;

    modport slave (
        input  signal_in,
        input  start_in,
        input  abort_in,
        input  counter_digits_in,
        input  counter_carry_in,
        output counter_reset_out,
        output counter_enable_out,
        output result_out,
        output result_valid_out,
        output overflow_out,
        output busy_out
    );

    modport master (
        output signal_in,
        output start_in,
        output abort_in,
        output counter_digits_in,
        output counter_carry_in,
        input  counter_reset_out,
        input  counter_enable_out,
        input  result_out,
        input  result_valid_out,
        input  overflow_out,
        input  busy_out
    );
endinterface

// File: rtl/freq_gate_controller.sv
// ---------------------------------------------------------------------------
// freq_gate_controller
//
// Gate-time controller for a frequency counter. It synchronises the measured
// signal and detects its rising edges. For a window of exactly GATE_CYCLES
// clock cycles it sends those edges as count pulses into an external BCD
// counter chain. At the end of the window it latches the chain's value and
// records whether the chain wrapped during the window.
//
// Sequence: IDLE -> CLEAR -> GATE (GATE_CYCLES) -> SETTLE -> LATCH -> IDLE.
// abort_in returns the controller to IDLE from any state and overrides every
// other transition. When abort_in and start_in arrive together in IDLE, the
// controller stays in IDLE.
//
// Parameters:
//   DIGITS_NUM   BCD digit count of the counter chain (default 6).
//   GATE_CYCLES  gate window length in clk_in cycles, 2..2^24 (default 1e6).
//
// Ports:
//   clk_in       sole clock; all logic runs on the rising edge.
//   reset_n_in   asynchronous active-low reset. It must be released
//                synchronously to clk_in.
//   bus          freq_gate_controller_if.slave, which carries:
//                  signal_in, start_in, abort_in          (in)
//                  counter_digits_in, counter_carry_in    (in, from chain)
//                  counter_reset_out, counter_enable_out  (out, to chain)
//                  result_out, result_valid_out,
//                  overflow_out, busy_out                 (out)
//
// Build option:
//   FREQ_CTRL_AUTORESTART_EN  When this macro is defined, LATCH goes back to
//                             CLEAR instead of IDLE. One start_in then gives
//                             back-to-back measurements until abort_in or
//                             reset.
// ---------------------------------------------------------------------------
module freq_gate_controller #(
    parameter int DIGITS_NUM  = 6,
    parameter int GATE_CYCLES = 1000000
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    freq_gate_controller_if.slave  bus
);

    localparam int RES_W = 4 * DIGITS_NUM;
    localparam int CNT_W = $clog2(GATE_CYCLES + 1);

    localparam logic [CNT_W-1:0] GATE_LOAD = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_GATE   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_LATCH  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             sig_meta;
    logic             sig_sync;
    logic             sig_prev;
    logic             sig_rise;
    logic [CNT_W-1:0] gate_cnt;
    logic             ovf_sticky;
    logic [RES_W-1:0] result_q;
    logic             result_valid_q;
    logic             overflow_q;

    // Two-flop synchroniser, plus one more flop for edge detection.
    // NOTE: sequential state always uses non-blocking assignments. This lets
    // every flop sample the pre-edge value of its neighbour, which is what
    // makes the shift chain behave as a pipeline.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sig_meta <= 1'b0;
            sig_sync <= 1'b0;
            sig_prev <= 1'b0;
        end else begin
            sig_meta <= bus.signal_in;
            sig_sync <= sig_meta;
            sig_prev <= sig_sync;
        end
    end

    assign sig_rise = sig_sync & ~sig_prev;

    // Next-state logic.
    // NOTE: state_nxt gets a default before the case statement. Every path
    // therefore assigns it, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (bus.abort_in) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (bus.start_in) state_nxt = ST_CLEAR;
                ST_CLEAR:  state_nxt = ST_GATE;
                ST_GATE:   if (gate_cnt == GATE_LAST) state_nxt = ST_SETTLE;
                // SETTLE gives the counter chain one cycle to absorb the
                // final gated edge before LATCH reads its value.
                ST_SETTLE: state_nxt = ST_LATCH;
`ifdef FREQ_CTRL_AUTORESTART_EN
                ST_LATCH:  state_nxt = ST_CLEAR;
`else
                ST_LATCH:  state_nxt = ST_IDLE;
`endif
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Gate counter. CLEAR loads GATE_CYCLES and every GATE cycle decrements
    // it. GATE ends on the cycle where the count reads 1, which gives a
    // window of exactly GATE_CYCLES cycles.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            gate_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            gate_cnt <= GATE_LOAD;
        end else if (state == ST_GATE) begin
            gate_cnt <= gate_cnt - GATE_LAST;
        end
    end

    // Sticky overflow flag. The carry can appear in the last GATE cycle or,
    // if the chain registers its carry, in SETTLE. Both cycles are covered.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ovf_sticky <= 1'b0;
        end else if (state == ST_CLEAR) begin
            ovf_sticky <= 1'b0;
        end else if ((state == ST_GATE || state == ST_SETTLE) && bus.counter_carry_in) begin
            ovf_sticky <= 1'b1;
        end
    end

    // Result capture. The valid pulse is registered together with
    // result_out, so it lines up with the cycle where the new value first
    // appears. An abort that lands in LATCH suppresses both the capture and
    // the pulse.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            result_q       <= '0;
            overflow_q     <= 1'b0;
            result_valid_q <= 1'b0;
        end else if (state == ST_LATCH && !bus.abort_in) begin
            result_q       <= bus.counter_digits_in;
            overflow_q     <= ovf_sticky;
            result_valid_q <= 1'b1;
        end else begin
            result_valid_q <= 1'b0;
        end
    end

    assign bus.counter_reset_out  = (state == ST_IDLE) || (state == ST_CLEAR);
    assign bus.counter_enable_out = sig_rise && (state == ST_GATE);
    assign bus.busy_out           = (state != ST_IDLE);
    assign bus.result_out         = result_q;
    assign bus.overflow_out       = overflow_q;
    assign bus.result_valid_out   = result_valid_q;

endmodule

// File: tb/tb_freq_gate_controller.sv
// ---------------------------------------------------------------------------
// tb_freq_gate_controller
//
// Bench for freq_gate_controller with GATE_CYCLES = 100. There are two
// instances: one with a 2-digit BCD counter chain and one with a 1-digit
// chain. The bench models each chain. When a measurement that should
// complete is started, its expected result is pushed to a per-instance
// queue. A monitor pops the queue on every result_valid_out pulse and
// compares.
// ---------------------------------------------------------------------------
module tb_freq_gate_controller;

    localparam int GATE = 100;

    typedef struct {
        logic [7:0] result;
        logic       ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    freq_gate_controller_if #(.DIGITS_NUM(2)) bus2 ();
    freq_gate_controller_if #(.DIGITS_NUM(1)) bus1 ();

    freq_gate_controller #(.DIGITS_NUM(2), .GATE_CYCLES(GATE)) u_dut2 (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus2)
    );

    freq_gate_controller #(.DIGITS_NUM(1), .GATE_CYCLES(GATE)) u_dut1 (
        .clk_in     (clk),
        .reset_n_in (rst_n),
        .bus        (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Measured signal: a square wave of sig_period clocks that changes on
    // the falling edge.
    int   sig_period = 4;
    int   ph         = 0;
    logic sig        = 1'b0;
    always @(negedge clk) begin
        ph  = (ph + 1 >= sig_period) ? 0 : ph + 1;
        sig = (ph < sig_period / 2);
    end

    logic start2 = 1'b0, abort2 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    assign bus2.signal_in = sig;
    assign bus1.signal_in = sig;
    assign bus2.start_in  = start2;
    assign bus2.abort_in  = abort2;
    assign bus1.start_in  = start1;
    assign bus1.abort_in  = abort1;

    // Models of the BCD counter chains: synchronous clear, a carry that is
    // combinational on wrap, and a digit update one cycle after the enable.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input int nd);
        logic [7:0] r;
        logic       c;
        logic [3:0] d;
        r = v;
        c = 1'b1;
        for (int i = 0; i < nd; i++) begin
            d = r[4*i +: 4];
            if (c) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d = d + 4'd1;
                    c = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    logic [7:0] cnt2;
    logic [3:0] cnt1;
    logic [7:0] cnt1_next;
    assign cnt1_next = bcd_inc({4'h0, cnt1}, 1);

    always_ff @(posedge clk) begin
        if (bus2.counter_reset_out)       cnt2 <= 8'h00;
        else if (bus2.counter_enable_out) cnt2 <= bcd_inc(cnt2, 2);
        if (bus1.counter_reset_out)       cnt1 <= 4'h0;
        else if (bus1.counter_enable_out) cnt1 <= cnt1_next[3:0];
    end

    assign bus2.counter_digits_in = cnt2;
    assign bus2.counter_carry_in  = bus2.counter_enable_out && (cnt2 == 8'h99);
    assign bus1.counter_digits_in = cnt1;
    assign bus1.counter_carry_in  = bus1.counter_enable_out && (cnt1 == 4'h9);

    // Scoreboard and monitors.
    exp_t q2[$];
    exp_t q1[$];
    int   v2_cnt = 0;
    int   v1_cnt = 0;
    int   cyc    = 0;
    int   last_valid_cyc2 = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus2.result_valid_out) begin
`ifdef FREQ_CTRL_AUTORESTART_EN
            if (v2_cnt > 0) check("valid_interval", 32'(cyc - last_valid_cyc2), 32'(GATE + 3));
`endif
            last_valid_cyc2 = cyc;
            v2_cnt++;
            if (q2.size() == 0) begin
                check("unexpected_valid2", 32'(bus2.result_valid_out), 32'd0);
            end else begin
                e = q2.pop_front();
                check("result2", 32'(bus2.result_out), 32'(e.result));
                check("overflow2", 32'(bus2.overflow_out), 32'(e.ovf));
            end
        end
        if (rst_n && bus1.result_valid_out) begin
            v1_cnt++;
            if (q1.size() == 0) begin
                check("unexpected_valid1", 32'(bus1.result_valid_out), 32'd0);
            end else begin
                e = q1.pop_front();
                check("result1", 32'(bus1.result_out), 32'(e.result));
                check("overflow1", 32'(bus1.overflow_out), 32'(e.ovf));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic pulse_abort2();
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
    endtask

    // Counts busy cycles from the current one onwards. The count has a bound.
    task automatic wait_idle2(output int busy_cycles);
        int n = 0;
        while (bus2.busy_out && n < 400) begin
            n++;
            @(negedge clk);
        end
        busy_cycles = n;
        check("idle_timeout", 32'(bus2.busy_out), 32'd0);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_result"},    32'(bus2.result_out),         32'd0);
        check({pfx, "_valid"},     32'(bus2.result_valid_out),   32'd0);
        check({pfx, "_overflow"},  32'(bus2.overflow_out),       32'd0);
        check({pfx, "_busy"},      32'(bus2.busy_out),           32'd0);
        check({pfx, "_enable"},    32'(bus2.counter_enable_out), 32'd0);
        check({pfx, "_cnt_reset"}, 32'(bus2.counter_reset_out),  32'd1);
    endtask

    initial begin
        int n;
        tick(3);
        check_reset_outputs("rst");
        check("rst_busy1", 32'(bus1.busy_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("idle_busy", 32'(bus2.busy_out), 32'd0);

`ifdef FREQ_CTRL_AUTORESTART_EN
        // Back-to-back measurements at period 5 give 20 edges per window.
        sig_period = 5;
        tick(8);
        for (int i = 0; i < 3; i++) q2.push_back('{8'h20, 1'b0});
        pulse_start2();
        n = 0;
        while (v2_cnt < 3 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("autorestart_valids", 32'(v2_cnt), 32'd3);
        pulse_abort2();
        check("autorestart_abort_busy", 32'(bus2.busy_out), 32'd0);
        tick(200);
        check("autorestart_stopped", 32'(v2_cnt), 32'd3);
        check("autorestart_drained", 32'(q2.size()), 32'd0);
`else
        // Single measurement at period 4: 25 edges. The 2-digit chain
        // reads 25 and the 1-digit chain wraps to 5 with overflow.
        sig_period = 4;
        tick(8);
        q2.push_back('{8'h25, 1'b0});
        q1.push_back('{8'h05, 1'b1});
        start1 = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        check("clear_busy", 32'(bus2.busy_out), 32'd1);
        check("clear_cnt_reset", 32'(bus2.counter_reset_out), 32'd1);
        wait_idle2(n);
        check("busy_cycles", 32'(n), 32'(GATE + 3));
        tick(2);
        check("valid_count_a2", 32'(v2_cnt), 32'd1);
        check("valid_count_a1", 32'(v1_cnt), 32'd1);
        check("drained_a2", 32'(q2.size()), 32'd0);
        check("drained_a1", 32'(q1.size()), 32'd0);

        // With autorestart disabled, nothing happens without a new start.
        tick(150);
        check("no_restart_busy", 32'(bus2.busy_out), 32'd0);
        check("no_restart_valid", 32'(v2_cnt), 32'd1);
        check("result_hold", 32'(bus2.result_out), 32'h25);

        // Abort 50 cycles into GATE at period 5. The old result must stay.
        sig_period = 5;
        pulse_start2();
        tick(51);
        check("gate_cnt_reset", 32'(bus2.counter_reset_out), 32'd0);
        pulse_abort2();
        check("abort_busy", 32'(bus2.busy_out), 32'd0);
        tick(150);
        check("abort_no_valid", 32'(v2_cnt), 32'd1);
        check("abort_result_hold", 32'(bus2.result_out), 32'h25);

        // Abort that lands exactly in LATCH.
        pulse_start2();
        tick(102);
        pulse_abort2();
        check("latch_abort_busy", 32'(bus2.busy_out), 32'd0);
        tick(5);
        check("latch_abort_no_valid", 32'(v2_cnt), 32'd1);
        check("latch_abort_result", 32'(bus2.result_out), 32'h25);

        // Abort beats start when both arrive together.
        start2 = 1'b1;
        abort2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        abort2 = 1'b0;
        check("abort_over_start", 32'(bus2.busy_out), 32'd0);
        tick(5);

        // A start during GATE is ignored. Exactly one result appears.
        q2.push_back('{8'h20, 1'b0});
        pulse_start2();
        tick(30);
        pulse_start2();
        wait_idle2(n);
        check("busy_cycles_restart", 32'(31 + n), 32'(GATE + 3));
        tick(150);
        check("restart_single_valid", 32'(v2_cnt), 32'd2);

        // The next start from IDLE is accepted.
        sig_period = 4;
        tick(8);
        q2.push_back('{8'h25, 1'b0});
        pulse_start2();
        check("restart_accept", 32'(bus2.busy_out), 32'd1);
        wait_idle2(n);
        tick(2);
        check("restart_valid", 32'(v2_cnt), 32'd3);
        check("drained_c", 32'(q2.size()), 32'd0);

        // Reset mid-GATE: outputs change immediately and no result follows.
        pulse_start2();
        tick(40);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick(200);
        check("midrst_no_valid", 32'(v2_cnt), 32'd3);
        check("midrst_idle", 32'(bus2.busy_out), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
